link_peer: RTL

Link-cable peer: the far end of the emulator's Game Boy serial port, acting as the "other Game Boy" on the link pins. It tracks the GB-driven serial clock, samples the GB's data output, and shifts a locally supplied byte back. Each completed 8-bit exchange is handed to the system side (ESP32 bridge or printer/adapter emulation) as a received byte. The block sits beside the emulator top, wired to the same pins: peer input = emulator LINK_OUT, peer output = emulator LINK_IN, clock shared on LINK_CLK.

---
 rtl/link_peer_pkg.sv | 18 +
 rtl/link_peer_sync.sv | 39 +++
 rtl/link_peer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/link_peer_pkg.sv
// link_peer_pkg: shared constants and types for the link-cable peer.
//   IDLE_BYTE     value the transmit shifter holds when nothing is queued
//   BIT_CNT_W     width of the received-bit counter (8 bits per byte)
//   TIMEOUT_W     width used to derive the default abort timeout
//   peer_state_e  exchange state: idle, slave shifting, or master clocking
package link_peer_pkg;

  localparam logic [7:0] IDLE_BYTE = 8'hFF;
  localparam int         BIT_CNT_W = 3;
  localparam int         TIMEOUT_W = 16;

  typedef enum logic [1:0] {
    PEER_IDLE,
    PEER_SHIFT,
    PEER_MASTER
  } peer_state_e;

endpackage

// File: rtl/link_peer_sync.sv
// link_peer_sync: two-flop synchroniser for an asynchronous link pin, plus a
// third flop so edges can be detected. All flops reset to 1, which matches
// the idle-high level of the link clock and data lines.
// Ports:
//   hclk   system clock
//   reset  asynchronous, active-high reset
//   pin    raw asynchronous pin
//   level  synchronised level
//   rise   one-cycle strobe on a synchronised 0->1 transition
//   fall   one-cycle strobe on a synchronised 1->0 transition
module link_peer_sync (
  input  logic hclk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // Synchroniser chain; s3 is the previous synchronised level for edge detection.
  always_ff @(posedge hclk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= pin;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/link_peer.sv
// link_peer: far end of the Game Boy serial link. Follows the GB-driven link
// clock, samples the GB's data on each rising clock edge and shifts a locally
// queued byte back MSB-first. Completed bytes are presented on rx_data with a
// one-cycle rx_valid pulse. A partial byte is aborted after TIMEOUT hclk
// cycles without a rising edge.
// Optional feature macro: LINK_PEER_CLKGEN_EN adds a clock generator so the
// peer can act as the clock master (master_mode/start); without it those
// inputs are ignored and the clock pin is never driven.
// Ports:
//   hclk, reset                 system clock, async active-high reset
//   enable                      peer active; low forces idle
//   link_clk_in, link_sin       raw asynchronous link pins from the GB
//   link_clk_out, link_clk_oe   generated clock and its drive enable
//   link_sout                   serial data to the GB
//   tx_data, tx_valid, tx_ready byte handshake into the holding register
//   rx_data, rx_valid           last received byte and its update pulse
//   master_mode, start          clock-master controls
//   busy                        byte in progress or master exchange running
//   timeout_err                 pulse when a partial byte is aborted
module link_peer
  import link_peer_pkg::*;
#(
  parameter int HALF_PERIOD = 2048,
  parameter int TIMEOUT     = (1 << TIMEOUT_W) - 1
) (
  input  logic       hclk,
  input  logic       reset,
  input  logic       enable,
  input  logic       link_clk_in,
  output logic       link_clk_out,
  output logic       link_clk_oe,
  input  logic       link_sin,
  output logic       link_sout,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       master_mode,
  input  logic       start,
  output logic       busy,
  output logic       timeout_err
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  peer_state_e          state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [IDLE_W-1:0]    idle_cnt;
  logic [7:0]           tx_sr;
  logic [7:0]           hold;
  logic [7:0]           rx_sr;
  logic                 hold_v;
  logic                 tx_loaded;

  logic clk_rise, clk_s_unused, clk_fall_unused;
  logic sin_s, sin_rise_unused, sin_fall_unused;
  logic rx_msb_unused;
  logic accept, timeout_hit, abort, rise_evt, start_ok, master_abort;

  link_peer_sync u_clk_sync (
    .hclk  (hclk),
    .reset (reset),
    .pin   (link_clk_in),
    .level (clk_s_unused),
    .rise  (clk_rise),
    .fall  (clk_fall_unused)
  );

  link_peer_sync u_sin_sync (
    .hclk  (hclk),
    .reset (reset),
    .pin   (link_sin),
    .level (sin_s),
    .rise  (sin_rise_unused),
    .fall  (sin_fall_unused)
  );

  // The top receive bit is shifted out into rx_data, never read from rx_sr.
  assign rx_msb_unused = rx_sr[7];

  assign accept      = tx_valid & ~hold_v;
  assign timeout_hit = (bit_cnt != '0) && (idle_cnt == IDLE_W'(TIMEOUT));
  assign abort       = timeout_hit | master_abort;

`ifdef LINK_PEER_CLKGEN_EN
  localparam int DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             clk_out_q;
  logic             clk_oe_q;
  logic             gen_toggle;
  logic             gen_rise;

  // In master mode the generator's low-to-high toggle replaces the pin edge.
  assign gen_toggle   = (state == PEER_MASTER) && (div_cnt == DIV_W'(HALF_PERIOD - 1));
  assign gen_rise     = gen_toggle && !clk_out_q;
  assign rise_evt     = master_mode ? gen_rise : clk_rise;
  assign start_ok     = enable && master_mode && start && (state == PEER_IDLE);
  assign master_abort = (state == PEER_MASTER) && !master_mode;

  // Clock generator: each bit is HALF_PERIOD cycles low then HALF_PERIOD
  // high; the line rests high whenever no master exchange is running.
  always_ff @(posedge hclk or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      clk_out_q <= 1'b1;
      clk_oe_q  <= 1'b0;
    end else begin
      clk_oe_q <= enable & master_mode;
      if (!enable || abort) begin
        div_cnt   <= '0;
        clk_out_q <= 1'b1;
      end else if (start_ok) begin
        div_cnt   <= '0;
        clk_out_q <= 1'b0;
      end else if (state == PEER_MASTER) begin
        if (gen_toggle) begin
          div_cnt   <= '0;
          clk_out_q <= ~clk_out_q;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end else begin
        div_cnt   <= '0;
        clk_out_q <= 1'b1;
      end
    end
  end

  assign link_clk_out = clk_out_q;
  assign link_clk_oe  = clk_oe_q;
`else
  localparam int half_period_unused = HALF_PERIOD;
  logic cfg_unused;

  assign cfg_unused   = master_mode ^ start;
  assign rise_evt     = clk_rise;
  assign start_ok     = 1'b0;
  assign master_abort = 1'b0;
  assign link_clk_out = 1'b1;
  assign link_clk_oe  = 1'b0;
`endif

  // Exchange engine: holding register, shift registers, bit and idle counters.
  // A byte accepted on the same cycle as the 8th rise only reaches hold here;
  // it moves into tx_sr on the next idle cycle.
  always_ff @(posedge hclk or posedge reset) begin
    if (reset) begin
      state       <= PEER_IDLE;
      bit_cnt     <= '0;
      idle_cnt    <= '0;
      tx_sr       <= IDLE_BYTE;
      tx_loaded   <= 1'b0;
      hold        <= '0;
      hold_v      <= 1'b0;
      rx_sr       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      timeout_err <= 1'b0;
      if (accept) begin
        hold   <= tx_data;
        hold_v <= 1'b1;
      end
      if (!enable) begin
        state     <= PEER_IDLE;
        bit_cnt   <= '0;
        idle_cnt  <= '0;
        tx_sr     <= IDLE_BYTE;
        tx_loaded <= 1'b0;
      end else if (abort) begin
        state       <= PEER_IDLE;
        bit_cnt     <= '0;
        idle_cnt    <= '0;
        rx_sr       <= '0;
        tx_sr       <= IDLE_BYTE;
        tx_loaded   <= 1'b0;
        timeout_err <= 1'b1;
      end else if (rise_evt) begin
        idle_cnt <= '0;
        rx_sr    <= {rx_sr[6:0], sin_s};
        if (bit_cnt == {BIT_CNT_W{1'b1}}) begin
          state    <= PEER_IDLE;
          bit_cnt  <= '0;
          rx_data  <= {rx_sr[6:0], sin_s};
          rx_valid <= 1'b1;
          if (hold_v) begin
            tx_sr     <= hold;
            tx_loaded <= 1'b1;
            hold_v    <= 1'b0;
          end else begin
            tx_sr     <= IDLE_BYTE;
            tx_loaded <= 1'b0;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          tx_sr   <= {tx_sr[6:0], 1'b1};
          if (state == PEER_IDLE) begin
            state <= PEER_SHIFT;
          end
        end
      end else begin
        if (start_ok) begin
          state <= PEER_MASTER;
        end
        if (bit_cnt != '0) begin
          idle_cnt <= idle_cnt + 1'b1;
        end
        if ((bit_cnt == '0) && !tx_loaded && hold_v) begin
          tx_sr     <= hold;
          tx_loaded <= 1'b1;
          hold_v    <= 1'b0;
        end
      end
    end
  end

  assign link_sout = tx_sr[7];
  assign tx_ready  = ~hold_v;
  assign busy      = (state != PEER_IDLE);

endmodule
